alu_serial_ctrl: RTL and testbench
==================================

# alu_serial_ctrl

Bit-serial word-level ALU sequencer that drives a single `ALU_1bit` slice over `WIDTH` cycles to compute a full-width result, one bit per clock, LSB first. It sits directly upstream of the 1-bit slice. It accepts a word operation over a valid/ready handshake and feeds the slice its per-bit operands and carry. It collects the slice's `result`, `c_out`, `set` and `overflow` outputs into word-level results and flags.

## Interface
- `WIDTH`, default 32: operand and result width in bits; must be ≥ 2.
- `clk`  in  1: clock; all state changes on the rising edge.
- `rst_n`  in  1: reset, synchronous and active-low.
- `in_valid`  in  1: operation request.
- `in_ready`  out  1: block can accept a request; high only in IDLE.
- `in_a`  in  WIDTH: operand A.
- `in_b`  in  WIDTH: operand B.
- `in_ctl`  in  4: `{Ainvert, Binvert, op[1:0]}`.
  - 0010 ADD, 0110 SUB, 0000 AND, 0001 OR, 1101 NAND, 1100 NOR, 0111 SLT.
- `out_valid`  out  1: result available.
- `out_ready`  in  1: consumer accepts result.
- `out_result`  out  WIDTH: word result.
- `out_c_out`  out  1: carry out of the MSB.
- `out_overflow`  out  1: signed overflow.
- `out_zero`  out  1: `out_result == 0`. Present only with the macro in Configuration.

## Operation
- FSM states: IDLE, RUN, DONE.
- **IDLE**
  - `in_ready=1`.
  - When `in_valid && in_ready`, latch `in_a`, `in_b`, `in_ctl`; set bit counter to 0; set carry register to `Binvert`. Go to RUN.
- **RUN**
  - Each cycle, drive the slice combinationally:
    - `a = A[cnt]`, `b = B[cnt]`, `c_in = carry`, `less = 0`.
    - `Ainvert`, `Binvert`, `op` come from the latched ctl.
  - On the edge:
    - `res[cnt] <= slice.result`.
    - `carry <= slice.c_out`.
    - `cnt <= cnt+1`.
  - At `cnt == WIDTH-1`, also capture `set_r <= slice.set` and `ovf_r <= slice.overflow`. Go to DONE.
- **Word flag rules**
  - Arithmetic ops (`op[1]=1`: ADD, SUB, SLT): `out_c_out` = final carry, `out_overflow` = `ovf_r`.
  - Logic ops: both forced to 0.
  - SLT: `out_result = {{(WIDTH-1){1'b0}}, set_r}`, where `set_r` is the uncorrected MSB sum bit from the slice. All other ops: `out_result = res`.
- **DONE**
  - `out_valid=1`; outputs held stable until `out_valid && out_ready`, then go to IDLE.
- **Edge cases**
  - Codes outside the seven listed are executed as-is through the slice with `less=0`, no error flag. `op[1]` selects the flag rule.
  - `in_valid` is ignored outside IDLE; operands are never re-sampled mid-operation.
  - Counter is `$clog2(WIDTH)` bits and never wraps: the transition to DONE happens at `WIDTH-1`.

## Timing
- Request accepted at edge E0. RUN processes bit k between edges E(k) and E(k+1).
- `out_valid` rises after edge E(WIDTH): latency is `WIDTH` cycles from acceptance.
- Consumer handshake at edge Ed returns the block to IDLE; `in_ready` is high after Ed. The next accept is no earlier than Ed+1.
- Minimum period is `WIDTH+2` cycles per operation with `out_ready` held high.
- **Reset**
  - `rst_n=0` at any edge, including mid-RUN or in DONE, sends the FSM to IDLE and drops the operation.
  - Reset values: `in_ready=1` (asserted in IDLE); `out_valid=0`; `out_result=0`; `out_c_out=0`; `out_overflow=0`; `out_zero=0`.
  - Internal carry, counter and shift register are cleared.

## Configuration
- `ALU_SERIAL_ZERO_EN`
  - Defined: `out_zero` port exists and equals `(out_result == 0)` while `out_valid`, 0 otherwise. Computed from a registered zero-tracking bit updated each RUN cycle, not a wide OR at output.
  - Undefined: port and tracking logic are omitted.

## Structure
- Shared package `alu_pkg` holds:
  - the seven 4-bit ctl codes (`ALU_CTL_ADD`, `ALU_CTL_SUB`, `ALU_CTL_AND`, `ALU_CTL_OR`, `ALU_CTL_NAND`, `ALU_CTL_NOR`, `ALU_CTL_SLT`);
  - the FSM state encoding.
- One sub-module: the existing `ALU_1bit`, instantiated once. No other hierarchy.

## Test plan
- WIDTH=8, ADD 8'h7F+8'h01 → `out_result`=8'h80, `out_overflow`=1, `out_c_out`=0, `out_valid` exactly 8 cycles after accept.
- WIDTH=8, SUB 8'h05−8'h05 → `out_result`=0, `out_c_out`=1, `out_overflow`=0, `out_zero`=1 (macro defined).
- WIDTH=8, SLT a=3, b=5 → `out_result`=8'h01. Swapped (a=5, b=3) → 8'h00.
- WIDTH=8, NOR 8'hF0,8'h0C → 8'h03; NAND same operands → 8'hFF; `out_overflow`=`out_c_out`=0.
- Backpressure: `out_ready`=0 for 5 cycles after `out_valid` → result held constant, `in_ready`=0; new `in_valid` ignored until after the handshake.
- Reset asserted at RUN cycle 4 of an ADD → next edge IDLE, all outputs at reset values. A following ADD 8'h01+8'h01 returns 8'h02.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the bit-serial ALU sequencer.
//   - 4-bit ALU control codes {Ainvert, Binvert, op[1:0]}
//   - FSM state encoding for alu_serial_ctrl
//   - helper to classify a control code as arithmetic (flags meaningful)
package alu_pkg;

  localparam logic [3:0] ALU_CTL_AND  = 4'b0000;
  localparam logic [3:0] ALU_CTL_OR   = 4'b0001;
  localparam logic [3:0] ALU_CTL_ADD  = 4'b0010;
  localparam logic [3:0] ALU_CTL_SUB  = 4'b0110;
  localparam logic [3:0] ALU_CTL_SLT  = 4'b0111;
  localparam logic [3:0] ALU_CTL_NOR  = 4'b1100;
  localparam logic [3:0] ALU_CTL_NAND = 4'b1101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // op[1] set means the adder path is in use, so carry/overflow are meaningful.
  function automatic logic is_arith(input logic [3:0] ctl);
    return ctl[1];
  endfunction

endpackage

// File: rtl/ALU_1bit.sv
// One-bit ALU slice (classic MIPS-style ripple element).
// Ports:
//   a, b        operand bits
//   c_in        carry in
//   less        value passed through on op=11 (SLT result path)
//   a_invert    invert a before use
//   b_invert    invert b before use
//   op[1:0]     00 AND, 01 OR, 10 SUM, 11 LESS
//   result      selected result bit
//   c_out       carry out of the full adder
//   set         raw sum bit (used at the MSB for SLT)
//   overflow    c_in ^ c_out (meaningful at the MSB only)
module ALU_1bit (
  input  logic       a,
  input  logic       b,
  input  logic       c_in,
  input  logic       less,
  input  logic       a_invert,
  input  logic       b_invert,
  input  logic [1:0] op,
  output logic       result,
  output logic       c_out,
  output logic       set,
  output logic       overflow
);

  logic aa;
  logic bb;
  logic sum;

  assign aa       = a ^ a_invert;
  assign bb       = b ^ b_invert;
  assign sum      = aa ^ bb ^ c_in;
  assign c_out    = (aa & bb) | (aa & c_in) | (bb & c_in);
  assign set      = sum;
  assign overflow = c_in ^ c_out;

  always_comb begin
    case (op)
      2'b00:   result = aa & bb;
      2'b01:   result = aa | bb;
      2'b10:   result = sum;
      default: result = less;
    endcase
  end

endmodule

// File: rtl/alu_serial_ctrl.sv
// Bit-serial word ALU sequencer: drives one ALU_1bit slice for WIDTH cycles,
// LSB first, and assembles the word result and flags.
// Parameters:
//   WIDTH        operand/result width (>= 2)
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   in_valid/in_ready, in_a, in_b, in_ctl   request channel
//   out_valid/out_ready, out_result, out_c_out, out_overflow   result channel
//   out_zero     result-is-zero flag, only when ALU_SERIAL_ZERO_EN is defined
// Build option: `define ALU_SERIAL_ZERO_EN adds out_zero and its tracking bit.
module alu_serial_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [3:0]       in_ctl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_c_out,
  output logic             out_overflow
`ifdef ALU_SERIAL_ZERO_EN
  ,
  output logic             out_zero
`endif
);

  localparam int CW = $clog2(WIDTH);

  state_t           state;
  state_t           next_state;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [3:0]       ctl_r;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic [WIDTH-1:0] res;
  logic             set_r;
  logic             ovf_r;
  logic             last_bit;
  logic             is_slt;
  logic [WIDTH-1:0] word;

  logic slice_result;
  logic slice_c_out;
  logic slice_set;
  logic slice_overflow;

  ALU_1bit u_slice (
    .a        (a_r[cnt]),
    .b        (b_r[cnt]),
    .c_in     (carry),
    .less     (1'b0),
    .a_invert (ctl_r[3]),
    .b_invert (ctl_r[2]),
    .op       (ctl_r[1:0]),
    .result   (slice_result),
    .c_out    (slice_c_out),
    .set      (slice_set),
    .overflow (slice_overflow)
  );

  assign last_bit = (cnt == CW'(WIDTH - 1));
  assign is_slt   = (ctl_r == ALU_CTL_SLT);
  assign word     = is_slt ? {{(WIDTH-1){1'b0}}, set_r} : res;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // NOTE: every output and next_state gets a default first, so no path through
  // the case statement can leave a value unassigned and infer a latch.
  always_comb begin
    next_state   = state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    out_result   = '0;
    out_c_out    = 1'b0;
    out_overflow = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) next_state = RUN;
      end
      RUN: begin
        if (last_bit) next_state = DONE;
      end
      DONE: begin
        out_valid    = 1'b1;
        out_result   = word;
        out_c_out    = is_arith(ctl_r) & carry;
        out_overflow = is_arith(ctl_r) & ovf_r;
        if (out_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // NOTE: the datapath registers are reset explicitly (not just the FSM) so a
  // dropped operation leaves no stale carry, count or partial result behind.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_r   <= '0;
      b_r   <= '0;
      ctl_r <= '0;
      cnt   <= '0;
      carry <= 1'b0;
      res   <= '0;
      set_r <= 1'b0;
      ovf_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_r   <= in_a;
            b_r   <= in_b;
            ctl_r <= in_ctl;
            cnt   <= '0;
            // Binvert doubles as the +1 of two's-complement subtraction.
            carry <= in_ctl[2];
          end
        end
        RUN: begin
          res[cnt] <= slice_result;
          carry    <= slice_c_out;
          if (last_bit) begin
            set_r <= slice_set;
            ovf_r <= slice_overflow;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef ALU_SERIAL_ZERO_EN
  // Running AND of inverted result bits; avoids a wide OR on the output path.
  logic zero_r;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      zero_r <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      zero_r <= 1'b1;
    end else if (state == RUN) begin
      zero_r <= zero_r & ~slice_result;
    end
  end

  // SLT replaces the word with the set bit, so its zero flag follows set_r.
  assign out_zero = (state == DONE) & (is_slt ? ~set_r : zero_r);
`endif

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Directed testbench for alu_serial_ctrl at WIDTH=8 with hand-computed
// expected results. Compile with ALU_SERIAL_ZERO_EN to also check out_zero.
module tb_alu_serial_ctrl;
  import alu_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic [3:0]   in_ctl;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_result;
  logic         out_c_out;
  logic         out_overflow;
`ifdef ALU_SERIAL_ZERO_EN
  logic         out_zero;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  alu_serial_ctrl #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_a         (in_a),
    .in_b         (in_b),
    .in_ctl       (in_ctl),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_c_out    (out_c_out),
    .out_overflow (out_overflow)
`ifdef ALU_SERIAL_ZERO_EN
    ,
    .out_zero     (out_zero)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept a request and wait (bounded) for out_valid; checks the latency.
  task automatic start_and_wait(input string tag, input logic [W-1:0] a,
                                input logic [W-1:0] b, input logic [3:0] ctl);
    int cycles;
    check({tag, "_in_ready"}, in_ready, 1'b1);
    in_a     = a;
    in_b     = b;
    in_ctl   = ctl;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    cycles   = 0;
    while (!out_valid && cycles < 40) begin
      tick();
      cycles++;
    end
    check({tag, "_latency"}, cycles, W);
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_valid_drop"}, out_valid, 1'b0);
    check({tag, "_ready_back"}, in_ready, 1'b1);
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [3:0] ctl, input logic [W-1:0] exp_res,
                        input logic exp_c, input logic exp_ovf);
    start_and_wait(tag, a, b, ctl);
    check({tag, "_result"}, out_result, exp_res);
    check({tag, "_c_out"}, out_c_out, exp_c);
    check({tag, "_ovf"}, out_overflow, exp_ovf);
`ifdef ALU_SERIAL_ZERO_EN
    check({tag, "_zero"}, out_zero, exp_res == '0);
`endif
    handshake(tag);
  endtask

  logic [W-1:0] held;

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_ctl    = '0;
    out_ready = 1'b0;
    tick();
    tick();

    // Reset state
    check("rst_in_ready",  in_ready,     1'b1);
    check("rst_out_valid", out_valid,    1'b0);
    check("rst_result",    out_result,   8'h00);
    check("rst_c_out",     out_c_out,    1'b0);
    check("rst_ovf",       out_overflow, 1'b0);
`ifdef ALU_SERIAL_ZERO_EN
    check("rst_zero",      out_zero,     1'b0);
`endif
    rst_n = 1'b1;
    tick();

    //      tag         a      b      ctl           result c     ovf
    run_op("add_ovf",  8'h7F, 8'h01, ALU_CTL_ADD,  8'h80, 1'b0, 1'b1);
    run_op("add_wrap", 8'hFF, 8'h01, ALU_CTL_ADD,  8'h00, 1'b1, 1'b0);
    run_op("sub_zero", 8'h05, 8'h05, ALU_CTL_SUB,  8'h00, 1'b1, 1'b0);
    run_op("sub_ovf",  8'h80, 8'h01, ALU_CTL_SUB,  8'h7F, 1'b1, 1'b1);
    run_op("slt_lt",   8'h03, 8'h05, ALU_CTL_SLT,  8'h01, 1'b0, 1'b0);
    run_op("slt_ge",   8'h05, 8'h03, ALU_CTL_SLT,  8'h00, 1'b1, 1'b0);
    run_op("nor",      8'hF0, 8'h0C, ALU_CTL_NOR,  8'h03, 1'b0, 1'b0);
    run_op("nand",     8'hF0, 8'h0C, ALU_CTL_NAND, 8'hFF, 1'b0, 1'b0);
    run_op("and",      8'hF0, 8'h3C, ALU_CTL_AND,  8'h30, 1'b0, 1'b0);
    run_op("or",       8'hF0, 8'h0C, ALU_CTL_OR,   8'hFC, 1'b0, 1'b0);

    // Backpressure: result held, new requests ignored while in DONE.
    start_and_wait("bp", 8'h12, 8'h34, ALU_CTL_ADD);
    held     = out_result;
    check("bp_result", held, 8'h46);
    in_a     = 8'h11;
    in_b     = 8'h22;
    in_ctl   = ALU_CTL_SUB;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_hold_valid",  out_valid,  1'b1);
      check("bp_hold_result", out_result, 8'h46);
      check("bp_in_ready",    in_ready,   1'b0);
    end
    in_valid = 1'b0;
    handshake("bp");
    run_op("bp_next", 8'h11, 8'h22, ALU_CTL_ADD, 8'h33, 1'b0, 1'b0);

    // Reset during RUN drops the operation.
    in_a     = 8'h7F;
    in_b     = 8'h7F;
    in_ctl   = ALU_CTL_ADD;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    check("mid_rst_in_ready",  in_ready,     1'b1);
    check("mid_rst_out_valid", out_valid,    1'b0);
    check("mid_rst_result",    out_result,   8'h00);
    check("mid_rst_c_out",     out_c_out,    1'b0);
    check("mid_rst_ovf",       out_overflow, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < W + 2; i++) tick();
    check("mid_rst_dropped", out_valid, 1'b0);
    run_op("post_rst_add", 8'h01, 8'h01, ALU_CTL_ADD, 8'h02, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
